// File: rtl/dlfp_issue_decoder_pkg.sv
// rtl/dlfp_issue_decoder_pkg.sv - DLFloat16 FPU instruction encodings, packet type and decode function
package dlfp_issue_decoder_pkg;

    localparam logic [6:0] OPC_FP  = 7'b1011011;
    localparam logic [6:0] OPC_FMA = 7'b1000011;
    localparam logic [6:0] OPC_FMS = 7'b1000111;

    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_DIV    = 5'b00011;
    localparam logic [4:0] F5_SQRT   = 5'b01011;
    localparam logic [4:0] F5_SGNJ   = 5'b00100;
    localparam logic [4:0] F5_MINMAX = 5'b00101;
    localparam logic [4:0] F5_CMP    = 5'b10100;
    localparam logic [4:0] F5_I2F    = 5'b01000;
    localparam logic [4:0] F5_F2I    = 5'b01001;

    localparam logic [3:0] ENA_ADD  = 4'd1;
    localparam logic [3:0] ENA_MUL  = 4'd2;
    localparam logic [3:0] ENA_DIV  = 4'd3;
    localparam logic [3:0] ENA_SQRT = 4'd4;
    localparam logic [3:0] ENA_SGNJ = 4'd5;
    localparam logic [3:0] ENA_CMP  = 4'd6;
    localparam logic [3:0] ENA_I2F  = 4'd7;
    localparam logic [3:0] ENA_F2I  = 4'd8;
    localparam logic [3:0] ENA_FMA  = 4'd9;

    localparam logic [1:0] SEL1_J  = 2'b01;
    localparam logic [1:0] SEL1_JN = 2'b10;
    localparam logic [1:0] SEL1_JX = 2'b11;

    localparam logic [2:0] SEL2_MIN = 3'b001;
    localparam logic [2:0] SEL2_MAX = 3'b010;
    localparam logic [2:0] SEL2_EQ  = 3'b011;
    localparam logic [2:0] SEL2_LT  = 3'b100;
    localparam logic [2:0] SEL2_LE  = 3'b101;

    localparam logic [2:0] RM_DYN = 3'b111;

    typedef struct packed {
        logic [3:0] ena;
        logic       op;
        logic [1:0] sel1;
        logic [2:0] sel2;
        logic [2:0] rm;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
    } pkt_t;

    typedef struct packed {
        logic illegal;
        pkt_t pkt;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr, input logic [2:0] frm);
        dec_t       d;
        logic [4:0] fun5;
        logic [2:0] rm;
        logic       arith;
        d           = '0;
        fun5        = instr[31:27];
        rm          = instr[14:12];
        arith       = 1'b1;
        d.pkt.rd    = instr[11:7];
        d.pkt.rs1   = instr[19:15];
        d.pkt.rs2   = instr[24:20];
        d.pkt.rm    = rm;
        case (instr[6:0])
            OPC_FP: begin
                case (fun5)
                    F5_ADD:  d.pkt.ena = ENA_ADD;
                    F5_SUB:  begin d.pkt.ena = ENA_ADD; d.pkt.op = 1'b1; end
                    F5_MUL:  d.pkt.ena = ENA_MUL;
                    F5_DIV:  d.pkt.ena = ENA_DIV;
                    F5_SQRT: d.pkt.ena = ENA_SQRT;
                    F5_I2F:  d.pkt.ena = ENA_I2F;
                    F5_F2I:  d.pkt.ena = ENA_F2I;
                    F5_SGNJ: begin
                        arith     = 1'b0;
                        d.pkt.ena = ENA_SGNJ;
                        case (rm)
                            3'b000:  d.pkt.sel1 = SEL1_J;
                            3'b001:  d.pkt.sel1 = SEL1_JN;
                            3'b010:  d.pkt.sel1 = SEL1_JX;
                            default: d.illegal  = 1'b1;
                        endcase
                    end
                    F5_MINMAX: begin
                        arith     = 1'b0;
                        d.pkt.ena = ENA_CMP;
                        case (rm)
                            3'b000:  d.pkt.sel2 = SEL2_MIN;
                            3'b001:  d.pkt.sel2 = SEL2_MAX;
                            default: d.illegal  = 1'b1;
                        endcase
                    end
                    F5_CMP: begin
                        arith     = 1'b0;
                        d.pkt.ena = ENA_CMP;
                        case (rm)
                            3'b010:  d.pkt.sel2 = SEL2_EQ;
                            3'b001:  d.pkt.sel2 = SEL2_LT;
                            3'b000:  d.pkt.sel2 = SEL2_LE;
                            default: d.illegal  = 1'b1;
                        endcase
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OPC_FMA, OPC_FMS: begin
                d.pkt.ena = ENA_FMA;
                d.pkt.op  = instr[2];
                d.pkt.rs3 = fun5;
            end
            default: d.illegal = 1'b1;
        endcase
        // Arithmetic units take a real rounding mode; resolve dynamic from the CSR copy.
        if (arith && !d.illegal) begin
            if (rm == 3'b101 || rm == 3'b110) begin
                d.illegal = 1'b1;
            end else if (rm == RM_DYN) begin
                d.pkt.rm = frm;
                if (frm >= 3'b101) d.illegal = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/dlfp_issue_decoder_if.sv
// rtl/dlfp_issue_decoder_if.sv - instruction input and decoded-packet issue handshakes
interface dlfp_issue_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [2:0]  frm;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ena;
    logic        out_op;
    logic [1:0]  out_sel1;
    logic [2:0]  out_sel2;
    logic [2:0]  out_rm;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rs3;

    modport master (
        output in_valid, instr, frm, out_ready,
        input  in_ready, out_valid, out_ena, out_op, out_sel1, out_sel2, out_rm,
               out_rd, out_rs1, out_rs2, out_rs3
    );

    modport slave (
        input  in_valid, instr, frm, out_ready,
        output in_ready, out_valid, out_ena, out_op, out_sel1, out_sel2, out_rm,
               out_rd, out_rs1, out_rs2, out_rs3
    );
endinterface

// File: rtl/dlfp_sync_fifo.sv
// rtl/dlfp_sync_fifo.sv - registered synchronous FIFO with flush, no read bypass
module dlfp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == (PW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        dout = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/dlfp_issue_decoder.sv
// rtl/dlfp_issue_decoder.sv - buffered DLFloat16 instruction decoder with div/sqrt issue blocking
module dlfp_issue_decoder
    import dlfp_issue_decoder_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int DIV_LAT  = 12,
    parameter int SQRT_LAT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    dlfp_issue_decoder_if.slave  bus,
    output logic                 illegal,
    output logic                 div_busy,
    output logic                 sqrt_busy
);
    localparam int DIV_W  = $clog2(DIV_LAT + 1);
    localparam int SQRT_W = $clog2(SQRT_LAT + 1);

    dec_t              dec;
    pkt_t              head;
    pkt_t              out_pkt;
    logic              fifo_full, fifo_empty;
    logic              accept, push, pop, issue, blocked;
    logic              illegal_d, illegal_q;
    logic [DIV_W-1:0]  div_cnt_d, div_cnt_q;
    logic [SQRT_W-1:0] sqrt_cnt_d, sqrt_cnt_q;

    dlfp_sync_fifo #(
        .WIDTH ($bits(pkt_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (dec.pkt),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        dec       = decode(bus.instr, bus.frm);
        accept    = bus.in_valid && bus.in_ready;
        push      = accept && !dec.illegal;
        illegal_d = accept && dec.illegal;
        div_busy  = (div_cnt_q != '0);
        sqrt_busy = (sqrt_cnt_q != '0);
        blocked   = (head.ena == ENA_DIV && div_busy) || (head.ena == ENA_SQRT && sqrt_busy);
        issue     = !fifo_empty && !blocked && !flush;
        pop       = issue && bus.out_ready;
        // The issue cycle itself counts as the first busy cycle, so the next
        // div/sqrt can issue exactly LAT cycles later.
        div_cnt_d  = (div_cnt_q != '0) ? div_cnt_q - 1'b1 : div_cnt_q;
        sqrt_cnt_d = (sqrt_cnt_q != '0) ? sqrt_cnt_q - 1'b1 : sqrt_cnt_q;
        if (pop && head.ena == ENA_DIV)  div_cnt_d  = DIV_W'(DIV_LAT - 1);
        if (pop && head.ena == ENA_SQRT) sqrt_cnt_d = SQRT_W'(SQRT_LAT - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q  <= 1'b0;
            div_cnt_q  <= '0;
            sqrt_cnt_q <= '0;
        end else begin
            illegal_q  <= illegal_d;
            div_cnt_q  <= div_cnt_d;
            sqrt_cnt_q <= sqrt_cnt_d;
        end
    end

    assign out_pkt       = fifo_empty ? '0 : head;
    assign bus.in_ready  = rst_n && !fifo_full;
    assign bus.out_valid = issue;
    assign bus.out_ena   = out_pkt.ena;
    assign bus.out_op    = out_pkt.op;
    assign bus.out_sel1  = out_pkt.sel1;
    assign bus.out_sel2  = out_pkt.sel2;
    assign bus.out_rm    = out_pkt.rm;
    assign bus.out_rd    = out_pkt.rd;
    assign bus.out_rs1   = out_pkt.rs1;
    assign bus.out_rs2   = out_pkt.rs2;
    assign bus.out_rs3   = out_pkt.rs3;
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_dlfp_issue_decoder.sv
// tb/tb_dlfp_issue_decoder.sv - randomized self-checking bench for dlfp_issue_decoder
module tb_dlfp_issue_decoder;
    localparam int QDEPTH   = 4;
    localparam int DIV_LAT  = 12;
    localparam int SQRT_LAT = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic illegal, div_busy, sqrt_busy;

    dlfp_issue_decoder_if bus ();

    dlfp_issue_decoder #(
        .QDEPTH   (QDEPTH),
        .DIV_LAT  (DIV_LAT),
        .SQRT_LAT (SQRT_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .illegal   (illegal),
        .div_busy  (div_busy),
        .sqrt_busy (sqrt_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [32:0] exp_q [$];
    int          last_div  = -1000;
    int          last_sqrt = -1000;
    bit          exp_illegal = 1'b0;
    int          div_log [$];
    int          mul_log [$];
    logic [4:0]  f5_tab [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd4, 5'd5, 5'd20, 5'd8, 5'd9};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] f5, input logic [2:0] rm,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f5, 2'b00, rs2, rs1, rm, rd, opc};
    endfunction

    // Returns {illegal, ena, op, sel1, sel2, rm, rd, rs1, rs2, rs3}.
    function automatic logic [33:0] ref_decode(input logic [31:0] w, input logic [2:0] fr);
        int         unit;
        bit         bad, arith;
        logic       op;
        logic [1:0] s1;
        logic [2:0] s2, rmo, rm;
        logic [4:0] f, rs3;
        f = w[31:27]; rm = w[14:12];
        unit = 0; bad = 0; op = 0; s1 = '0; s2 = '0; rs3 = '0;
        if (w[6:0] == 7'h5B) begin
            case (f)
                5'd0:  unit = 1;
                5'd1:  begin unit = 1; op = 1; end
                5'd2:  unit = 2;
                5'd3:  unit = 3;
                5'd11: unit = 4;
                5'd8:  unit = 7;
                5'd9:  unit = 8;
                5'd4:  begin unit = 5; if (rm <= 2) s1 = 2'(rm + 1); else bad = 1; end
                5'd5:  begin unit = 6; if (rm <= 1) s2 = 3'(rm + 1); else bad = 1; end
                5'd20: begin unit = 6; if (rm <= 2) s2 = 3'(5 - rm); else bad = 1; end
                default: bad = 1;
            endcase
        end else if (w[6:0] == 7'h43 || w[6:0] == 7'h47) begin
            unit = 9; op = w[2]; rs3 = f;
        end else begin
            bad = 1;
        end
        arith = (unit != 5) && (unit != 6);
        rmo   = rm;
        if (arith && (rm == 3'd5 || rm == 3'd6)) bad = 1;
        if (arith && rm == 3'd7) begin
            rmo = fr;
            if (fr >= 3'd5) bad = 1;
        end
        return {bad, 4'(unit), op, s1, s2, rmo, w[11:7], w[19:15], w[24:20], rs3};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 7) begin
            w[6:0] = 7'h5B;
            if (k < 6) w[31:27] = f5_tab[$urandom_range(0, 9)];
        end else if (k < 9) begin
            w[6:0] = (k == 7) ? 7'h43 : 7'h47;
        end
        if ($urandom_range(0, 2) != 0) w[14:12] = 3'($urandom_range(0, 2));
        return w;
    endfunction

    // Called just after a rising edge; applies inputs, checks at the falling edge, advances the model.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [2:0] f, input bit ordy, input bit fl);
        logic [32:0] head;
        logic [33:0] r;
        bit          rdy, ov, dbusy, sbusy, acc, iss;
        int          hunit;
        bus.in_valid = v; bus.instr = ins; bus.frm = f; bus.out_ready = ordy; flush = fl;
        head  = (exp_q.size() > 0) ? exp_q[0] : '0;
        hunit = int'(head[32:29]);
        dbusy = (cyc - last_div >= 1) && (cyc - last_div < DIV_LAT);
        sbusy = (cyc - last_sqrt >= 1) && (cyc - last_sqrt < SQRT_LAT);
        rdy   = exp_q.size() < QDEPTH;
        ov    = (exp_q.size() > 0) && !fl && !(hunit == 3 && dbusy) && !(hunit == 4 && sbusy);
        @(negedge clk);
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(ov));
        chk("illegal", 64'(illegal), 64'(exp_illegal));
        chk("div_busy", 64'(div_busy), 64'(dbusy));
        chk("sqrt_busy", 64'(sqrt_busy), 64'(sbusy));
        chk("out_fields", 64'({bus.out_ena, bus.out_op, bus.out_sel1, bus.out_sel2, bus.out_rm,
                               bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_rs3}), 64'(head));
        if (bus.out_valid && bus.out_ready && bus.out_ena == 4'd3) div_log.push_back(cyc);
        if (bus.out_valid && bus.out_ready && bus.out_ena == 4'd2) mul_log.push_back(cyc);
        r   = ref_decode(ins, f);
        acc = v && rdy;
        iss = ov && ordy;
        exp_illegal = acc && r[33];
        if (iss && hunit == 3) last_div = cyc;
        if (iss && hunit == 4) last_sqrt = cyc;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (iss) void'(exp_q.pop_front());
            if (acc && !r[33]) exp_q.push_back(r[32:0]);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 3'd0, ordy, 1'b0);
    endtask

    initial begin
        int pct;
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.instr = '0; bus.frm = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_busy", 64'({div_busy, sqrt_busy}), 64'd0);
        chk("rst_fields", 64'({bus.out_ena, bus.out_op, bus.out_sel1, bus.out_sel2, bus.out_rm,
                               bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_rs3}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // add, visible one cycle after accept
        cycle(1'b1, mk(7'h5B, 5'd0, 3'd0, 5'd1, 5'd2, 5'd3), 3'd0, 1'b0, 1'b0);
        idle(2, 1'b1);

        // two divs back to back, then a mul that must wait behind the second
        div_log.delete(); mul_log.delete();
        cycle(1'b1, mk(7'h5B, 5'd3, 3'd0, 5'd4, 5'd5, 5'd6), 3'd0, 1'b1, 1'b0);
        cycle(1'b1, mk(7'h5B, 5'd3, 3'd1, 5'd7, 5'd8, 5'd9), 3'd0, 1'b1, 1'b0);
        cycle(1'b1, mk(7'h5B, 5'd2, 3'd0, 5'd10, 5'd11, 5'd12), 3'd0, 1'b1, 1'b0);
        idle(20, 1'b1);
        chk("div_count", 64'(div_log.size()), 64'd2);
        if (div_log.size() == 2) chk("div_gap", 64'(div_log[1] - div_log[0]), 64'(DIV_LAT));
        chk("mul_count", 64'(mul_log.size()), 64'd1);
        if (mul_log.size() == 1 && div_log.size() == 2)
            chk("mul_after_div", 64'(mul_log[0] > div_log[1]), 64'd1);

        // illegal sgnj rounding and unknown fun5
        cycle(1'b1, mk(7'h5B, 5'd4, 3'd3, 5'd1, 5'd1, 5'd1), 3'd0, 1'b0, 1'b0);
        cycle(1'b1, mk(7'h5B, 5'd31, 3'd0, 5'd1, 5'd1, 5'd1), 3'd0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // dynamic rounding: legal frm then reserved frm
        cycle(1'b1, mk(7'h5B, 5'd0, 3'd7, 5'd2, 5'd3, 5'd4), 3'd2, 1'b0, 1'b0);
        idle(2, 1'b1);
        cycle(1'b1, mk(7'h5B, 5'd0, 3'd7, 5'd2, 5'd3, 5'd4), 3'd5, 1'b0, 1'b0);
        idle(2, 1'b1);

        // fill to full, one pop, order kept
        for (int i = 0; i < 5; i++)
            cycle(1'b1, mk(7'h5B, 5'd2, 3'd0, 5'(i + 1), 5'd0, 5'd0), 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        cycle(1'b1, mk(7'h5B, 5'd8, 3'd1, 5'd20, 5'd21, 5'd22), 3'd0, 1'b0, 1'b0);
        idle(6, 1'b1);

        // fma with rs3, fill, then flush while full
        cycle(1'b1, {5'd7, 2'b00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h43}, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, {5'd9, 2'b00, 5'd3, 5'd2, 3'd1, 5'(i), 7'h47}, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, mk(7'h5B, 5'd31, 3'd0, 5'd0, 5'd0, 5'd0), 3'd0, 1'b1, 1'b1);
        idle(3, 1'b1);

        // randomized traffic with varying back-pressure
        pct = 90;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) pct = (n / 200 % 3 == 0) ? 90 : ((n / 200 % 3 == 1) ? 50 : 15);
            cycle(($urandom_range(0, 3) != 0), rand_instr(),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4)),
                  ($urandom_range(0, 99) < pct), ($urandom_range(0, 39) == 0));
        end
        idle(40, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
